// File: rtl/key_event.sv
// key_event: debounced key level to press/release/long/repeat pulses plus a wrapping press counter.
// Define KEY_AUTOREPEAT_EN to build the HELD-state auto-repeat; without it repeat_pulse stays 0.
module key_event #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       key_held,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {IDLE, DOWN, HELD} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("key_event: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    state_t           state_q, state_d;
    logic             key_q;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             press_q, press_d, rel_q, rel_d, long_q, long_d, rep_q, rep_d, held_q, held_d;
    logic             rise, fall;
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

    assign rise = key_in & ~key_q;
    assign fall = ~key_in & key_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_d  = rcnt_q;
`endif
        if (!enable) begin
            // Disabled: drop to IDLE silently, even a pending release is swallowed.
            state_d = IDLE;
            hold_d  = '0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d  = '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    press_d = 1'b1;
                    hold_d  = '0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = DOWN;
                end
                DOWN: if (fall) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    long_d  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d  = '0;
`endif
                    state_d = HELD;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
                HELD: if (fall) begin
                    rel_d   = 1'b1;
                    state_d = IDLE;
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rcnt_q == REP_LAST) begin
                    rep_d  = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        held_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= 1'b0;
            hold_q  <= '0;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_in;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = rep_q;
    assign key_held      = held_q;
    assign press_count   = cnt_q;
endmodule
